spi_master_tx_multi: RTL and testbench

//  Next-generation SPI master transmit datapath: parametrised word width, built-in prefetch FIFO,

---
 rtl/spi_master_tx_multi_if.sv | 40 ++++
 rtl/spi_master_tx_multi.sv | 172 +++++++++++++++++
 tb/tb_spi_master_tx_multi.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_tx_multi_if.sv
// spi_tx_if: bundles the SPI master transmit datapath's control, write and pad
// signals. The slave modport is the datapath view. The master modport is the
// controller/pad view.
//   en, tx_edge        beat strobe and its qualifier
//   mode, lsb_first    lane mode and bit order, captured at start
//   bit_count          transfer length in bits
//   count_upd          start strobe
//   data, data_valid,  write side of the prefetch FIFO
//   data_ready
//   sdo, sdo_oe        serial lanes and their output enables
//   busy, stall,       transfer status
//   tx_done
interface spi_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  en;
  logic                  tx_edge;
  logic [1:0]            mode;
  logic                  lsb_first;
  logic [CNT_WIDTH-1:0]  bit_count;
  logic                  count_upd;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  data_ready;
  logic [3:0]            sdo;
  logic [3:0]            sdo_oe;
  logic                  busy;
  logic                  stall;
  logic                  tx_done;

  modport master (
    output en, tx_edge, mode, lsb_first, bit_count, count_upd, data, data_valid,
    input  data_ready, sdo, sdo_oe, busy, stall, tx_done
  );
  modport slave (
    input  en, tx_edge, mode, lsb_first, bit_count, count_upd, data, data_valid,
    output data_ready, sdo, sdo_oe, busy, stall, tx_done
  );
endinterface

// File: rtl/spi_master_tx_multi.sv
// spi_master_tx_multi: SPI master transmit datapath.
// - Word width is a parameter.
// - Words are buffered in a prefetch FIFO.
// - The lane mode (single, dual or quad) is selected at run time.
// - Bit order is selectable: MSB first or LSB first.
// When a word boundary is reached with the FIFO empty, the block raises stall
// and holds the current beat. The clock generator can then pause SCLK.
// Ports:
//   clk, rstn  clock and asynchronous active-low reset
//   bus        spi_tx_if.slave. It carries the control, FIFO write and pad
//              signals.
module spi_master_tx_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int BUF_DEPTH  = 2
)(
  input  logic     clk,
  input  logic     rstn,
  spi_tx_if.slave  bus
);
  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STALL} state_t;
  state_t state, state_nx;

  // Prefetch FIFO. The pointers carry one extra bit to tell full from empty.
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  empty, full, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.data_valid && !full;
  assign bus.data_ready = !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Transfer context, latched at start. lmode encodes 0 = single,
  // 1 = dual, 2 = quad.
  logic [1:0]            lmode;
  logic                  lsb;
  logic [CNT_WIDTH-1:0]  tgt, beat, wbeat;
  logic [DATA_WIDTH-1:0] shreg, shifted;
  logic [CNT_WIDTH-1:0]  t_new, w_last;
  logic [1:0]            mode_new;
  logic [2:0]            lane_n;
  logic                  edge_acc, last, wb_end, start;

  // Decode the requested mode. The reserved encoding falls back to single.
  always_comb begin
    mode_new = 2'd0;
    t_new    = bus.bit_count;
    case (bus.mode)
      2'b01: begin mode_new = 2'd1; t_new = bus.bit_count >> 1; end
      2'b10: begin mode_new = 2'd2; t_new = bus.bit_count >> 2; end
      default: ;
    endcase
  end

  always_comb begin
    lane_n = 3'd1;
    w_last = CNT_WIDTH'(DATA_WIDTH - 1);
    case (lmode)
      2'd1: begin lane_n = 3'd2; w_last = CNT_WIDTH'(DATA_WIDTH/2 - 1); end
      2'd2: begin lane_n = 3'd4; w_last = CNT_WIDTH'(DATA_WIDTH/4 - 1); end
      default: ;
    endcase
  end

  assign edge_acc = (state == SHIFT) && bus.tx_edge && bus.en;
  assign last     = (beat == tgt - CNT_WIDTH'(1));
  assign wb_end   = (wbeat == w_last);
  assign shifted  = lsb ? (shreg >> lane_n) : (shreg << lane_n);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    start    = 1'b0;
    case (state)
      IDLE: if (bus.count_upd && t_new != '0) begin
        start    = 1'b1;
        state_nx = LOAD;
      end
      LOAD, STALL: if (!empty) begin
        pop      = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: if (edge_acc) begin
        if (last)        state_nx = IDLE;
        else if (wb_end) begin
          if (!empty) pop = 1'b1;
          else        state_nx = STALL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lmode   <= '0;
      lsb     <= 1'b0;
      tgt     <= '0;
      beat    <= '0;
      wbeat   <= '0;
      shreg   <= '0;
      bus.tx_done <= 1'b0;
    end else begin
      bus.tx_done <= edge_acc && last;
      if (start) begin
        lmode <= mode_new;
        lsb   <= bus.lsb_first;
        tgt   <= t_new;
        beat  <= '0;
        wbeat <= '0;
      end
      if (edge_acc && !last) beat <= beat + CNT_WIDTH'(1);
      if (pop) begin
        shreg <= mem[rd_ptr[AW-1:0]];
        wbeat <= '0;
      end else if (edge_acc) begin
        if (last) shreg <= '0;
        else if (!wb_end) begin
          shreg <= shifted;
          wbeat <= wbeat + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Lane mapping. Unused lanes stay 0, and everything is quiet in IDLE.
  always_comb begin
    bus.sdo    = '0;
    bus.sdo_oe = '0;
    if (state != IDLE) begin
      case (lmode)
        2'd1: begin
          bus.sdo[1:0] = lsb ? shreg[1:0] : shreg[DATA_WIDTH-1 -: 2];
          bus.sdo_oe   = 4'b0011;
        end
        2'd2: begin
          bus.sdo      = lsb ? shreg[3:0] : shreg[DATA_WIDTH-1 -: 4];
          bus.sdo_oe   = 4'b1111;
        end
        default: begin
          bus.sdo[0]   = lsb ? shreg[0] : shreg[DATA_WIDTH-1];
          bus.sdo_oe   = 4'b0001;
        end
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = (state == STALL);
endmodule

// File: tb/tb_spi_master_tx_multi.sv
module tb_spi_master_tx_multi;
  localparam int DW = 32, CW = 16, BD = 2;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  spi_tx_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  spi_master_tx_multi #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  int checks = 0, failures = 0;
  logic [DW-1:0] mq[$];       // words the model believes are queued in the FIFO
  logic [3:0]    exp_sdo[$];  // expected beat sequence of the current transfer
  logic [3:0]    exp_oe, seen_oe;
  int            exp_T, n_edges;
  logic [15:0]   first4;

  typedef struct {
    logic [1:0]    mode;
    logic          lsb;
    logic [CW-1:0] bc;
    logic [DW-1:0] word;
    int            t;
    logic [15:0]   f4;
    logic [3:0]    oe;
  } vec_t;
  vec_t tv[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic int lanes(input logic [1:0] m);
    return (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
  endfunction

  task automatic push(input logic [DW-1:0] w, input bit to_model);
    chk("push_ready", bus.data_ready, 1);
    bus.data = w; bus.data_valid = 1'b1;
    cyc();
    bus.data_valid = 1'b0;
    if (to_model) mq.push_back(w);
  endtask

  // Build the expected beat list straight from the word bits.
  task automatic model_prep(input logic [1:0] m, input logic l, input int bc);
    int L, W, need;
    logic [DW-1:0] w, v, mask;
    L = lanes(m); W = DW / L;
    exp_T = bc / L;
    need = (exp_T + W - 1) / W;
    mask = DW'((1 << L) - 1);
    exp_oe = 4'((1 << L) - 1);
    exp_sdo.delete();
    for (int i = 0; i < need; i++) begin
      w = mq.pop_front();
      for (int k = 0; k < W && exp_sdo.size() < exp_T; k++) begin
        v = l ? (w >> (L * k)) : (w >> (DW - L * (k + 1)));
        v = v & mask;
        exp_sdo.push_back(v[3:0]);
      end
    end
  endtask

  task automatic strobe_start(input logic [1:0] m, input logic l, input int bc);
    bus.mode = m; bus.lsb_first = l; bus.bit_count = CW'(bc); bus.count_upd = 1'b1;
    cyc();
    bus.count_upd = 1'b0;
    // Changing mode/order mid-transfer must have no effect.
    bus.mode = 2'($urandom); bus.lsb_first = 1'($urandom);
  endtask

  task automatic run_beats(input int start_idx, input bit noise);
    bit done = 0;
    int b = start_idx;
    n_edges = start_idx;
    while (!done && b < exp_T + 2) begin
      if (b < exp_T) chk("sdo", bus.sdo, exp_sdo[b]);
      if (b < 4) first4[15 - 4*b -: 4] = bus.sdo;
      chk("oe_busy_stall", {bus.sdo_oe, bus.busy, bus.stall}, {exp_oe, 1'b1, 1'b0});
      if (noise) begin
        repeat ($urandom_range(0, 2)) begin
          case ($urandom_range(0, 2))
            1: begin bus.tx_edge = 1'b1; bus.en = 1'b0; end
            2: begin bus.count_upd = 1'b1; bus.bit_count = CW'($urandom); end
            default: ;
          endcase
          cyc();
          bus.tx_edge = 1'b0; bus.en = 1'b1; bus.count_upd = 1'b0;
          if (b < exp_T) chk("sdo_hold", bus.sdo, exp_sdo[b]);
        end
      end
      bus.tx_edge = 1'b1; bus.en = 1'b1;
      cyc();
      bus.tx_edge = 1'b0;
      b++;
      n_edges = b;
      if (bus.tx_done) done = 1;
    end
    chk("done_seen", done, 1);
    chk("edge_count", n_edges, exp_T);
    chk("idle_outputs", {bus.sdo, bus.sdo_oe, bus.busy, bus.stall}, 0);
    cyc();
    chk("done_pulse_end", bus.tx_done, 0);
  endtask

  task automatic xfer(input logic [1:0] m, input logic l, input int bc, input bit noise);
    model_prep(m, l, bc);
    strobe_start(m, l, bc);
    chk("load_busy", bus.busy, 1);
    seen_oe = bus.sdo_oe;
    chk("load_oe", bus.sdo_oe, exp_oe);
    cyc();
    first4 = '0;
    run_beats(0, noise);
  endtask

  initial begin
    logic [DW-1:0] w0, w1, w2;
    bus.en = 1'b0; bus.tx_edge = 1'b0; bus.mode = '0; bus.lsb_first = 1'b0;
    bus.bit_count = '0; bus.count_upd = 1'b0; bus.data = '0; bus.data_valid = 1'b0;

    tv[0] = '{2'b00, 1'b0, 16'd8,  32'hA500_0000, 8, 16'h1010, 4'b0001};
    tv[1] = '{2'b10, 1'b1, 16'd32, 32'h8765_4321, 8, 16'h1234, 4'b1111};
    tv[2] = '{2'b01, 1'b0, 16'd13, 32'hC300_0000, 6, 16'h3003, 4'b0011};
    tv[3] = '{2'b11, 1'b1, 16'd5,  32'h0000_0016, 5, 16'h0110, 4'b0001};
    tv[4] = '{2'b10, 1'b0, 16'd7,  32'hF000_0000, 1, 16'hF000, 4'b1111};
    tv[5] = '{2'b01, 1'b1, 16'd3,  32'h0000_0002, 1, 16'h2000, 4'b0011};

    // Reset state
    cyc(); cyc();
    chk("rst_outputs", {bus.sdo, bus.sdo_oe, bus.busy, bus.stall, bus.tx_done}, 0);
    chk("rst_ready", bus.data_ready, 1);
    rstn = 1'b1;
    cyc();

    // Table vectors
    foreach (tv[i]) begin
      push(tv[i].word, 1);
      xfer(tv[i].mode, tv[i].lsb, int'(tv[i].bc), 1'(i % 2));
      chk("tbl_beats", n_edges, tv[i].t);
      chk("tbl_first4", first4, tv[i].f4);
      chk("tbl_oe", seen_oe, tv[i].oe);
    end

    // Underrun: 64 single beats with only one word available
    w0 = $urandom; w1 = $urandom;
    push(w0, 1);
    mq.push_back(w1);
    model_prep(2'b00, 1'b0, 64);
    strobe_start(2'b00, 1'b0, 64);
    cyc();
    for (int b = 0; b < 32; b++) begin
      chk("ur_sdo", bus.sdo, exp_sdo[b]);
      chk("ur_nostall", bus.stall, 0);
      bus.tx_edge = 1'b1; bus.en = 1'b1;
      cyc();
      bus.tx_edge = 1'b0;
    end
    chk("ur_stall", {bus.stall, bus.busy, bus.tx_done}, 3'b110);
    chk("ur_hold", bus.sdo, exp_sdo[31]);
    repeat (3) begin
      bus.tx_edge = 1'b1;
      cyc();
      bus.tx_edge = 1'b0;
      chk("ur_stall_edges", bus.stall, 1);
      chk("ur_hold_edges", bus.sdo, exp_sdo[31]);
    end
    push(w1, 0);
    chk("ur_stall_push", bus.stall, 1);
    cyc();
    chk("ur_resume", bus.stall, 0);
    run_beats(32, 0);

    // Prefetch to full, then start frees a slot
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    push(w0, 1); push(w1, 1);
    chk("pf_full", bus.data_ready, 0);
    model_prep(2'b00, 1'b1, 64);
    bus.data = w2; bus.data_valid = 1'b1;
    strobe_start(2'b00, 1'b1, 64);
    chk("pf_load_full", bus.data_ready, 0);
    cyc();
    chk("pf_pop_ready", bus.data_ready, 1);
    cyc();
    bus.data_valid = 1'b0;
    mq.push_back(w2);
    chk("pf_refull", bus.data_ready, 0);
    run_beats(0, 0);

    // Random transfers against the model; leftover words carry over
    for (int n = 0; n < 20; n++) begin
      logic [1:0] m;
      logic l;
      int L, bc, need;
      m = 2'($urandom); l = 1'($urandom);
      L = lanes(m);
      bc = $urandom_range(L, 2 * DW);
      need = ((bc / L) + DW / L - 1) / (DW / L);
      while (mq.size() < need) push($urandom, 1);
      xfer(m, l, bc, 1);
    end

    // Reset mid-transfer in quad mode
    if (mq.size() == 0) push($urandom, 1);
    model_prep(2'b10, 1'b0, 32);
    strobe_start(2'b10, 1'b0, 32);
    cyc();
    repeat (3) begin
      bus.tx_edge = 1'b1; bus.en = 1'b1;
      cyc();
      bus.tx_edge = 1'b0;
    end
    #2 rstn = 1'b0;
    #1;
    chk("midrst_outputs", {bus.sdo, bus.sdo_oe, bus.busy, bus.stall, bus.tx_done}, 0);
    chk("midrst_ready", bus.data_ready, 1);
    mq.delete();
    cyc();
    rstn = 1'b1;
    cyc();

    // Zero-length starts are ignored
    strobe_start(2'b00, 1'b0, 0);
    chk("zero_bc_busy", bus.busy, 0);
    strobe_start(2'b01, 1'b0, 1);
    chk("dual_T0_busy", bus.busy, 0);
    cyc();
    chk("zero_bc_busy2", bus.busy, 0);

    // FIFO was discarded: a fresh word is the one sent
    push(32'h5A00_0000, 1);
    xfer(2'b00, 1'b0, 8, 0);
    chk("post_rst_first4", first4, 16'h0101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
